// File: rtl/cpu_regs_pkg.sv
// Shared constants and FSM state type for the sequential register-file front end.
package cpu_regs_pkg;

    localparam int unsigned REGS_DW  = 32;
    localparam int unsigned REGS_AW  = 5;
    localparam int unsigned REGS_NUM = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD1,
        ST_RD2,
        ST_RESP
    } state_e;

endpackage

// File: rtl/cpu_regs_seq.sv
// Two-operand register read sequencer over a 1R1W regfile, with zero-fill after reset.
// Define CPU_REGS_SEQ_BYPASS_EN to forward a same-cycle write into the operand capture.
module cpu_regs_seq
    import cpu_regs_pkg::*;
#(
    parameter int unsigned DW = REGS_DW,
    parameter int unsigned AW = REGS_AW
) (
    input  logic          clk,
    input  logic          resetn,
    output logic          init_done,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_rs1,
    input  logic [AW-1:0] req_rs2,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata1,
    output logic [DW-1:0] rsp_rdata2,

    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,

    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_di,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_do
);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rs2_q;
    logic [DW-1:0] rdata1_q;
    logic [DW-1:0] rdata2_q;
    logic          init_done_q;
    logic          rsp_valid_q;

    logic          in_init;
    logic          wr_fire;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] cap_data;

    assign in_init   = (state_q == ST_INIT);
    assign wr_ready  = !in_init;
    assign wr_fire   = wr_valid && !in_init;
    assign req_ready = (state_q == ST_IDLE);

    assign init_done  = init_done_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata1 = rdata1_q;
    assign rsp_rdata2 = rdata2_q;

    always_comb begin
        rd_addr = '0;
        case (state_q)
            ST_RD1:  rd_addr = rs1_q;
            ST_RD2:  rd_addr = rs2_q;
            default: rd_addr = '0;
        endcase
    end

    // x0 always captures zero, overriding both the array and any forwarded write.
    always_comb begin
        cap_data = rf_do;
`ifdef CPU_REGS_SEQ_BYPASS_EN
        if (wr_fire && (wr_addr == rd_addr)) begin
            cap_data = wr_data;
        end
`endif
        if (rd_addr == '0) begin
            cap_data = '0;
        end
    end

    always_comb begin
        rf_we    = in_init ? 1'b1 : (wr_fire && (wr_addr != '0));
        rf_waddr = in_init ? cnt_q : wr_addr;
        rf_di    = in_init ? '0 : wr_data;
        rf_raddr = rd_addr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == '1) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        rs1_q   <= req_rs1;
                        rs2_q   <= req_rs2;
                        state_q <= ST_RD1;
                    end
                end
                ST_RD1: begin
                    rdata1_q <= cap_data;
                    state_q  <= ST_RD2;
                end
                ST_RD2: begin
                    rdata2_q    <= cap_data;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_regs_seq.sv
// Self-checking bench for cpu_regs_seq: directed table, corner sequences and random traffic.
module tb_cpu_regs_seq;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

`ifdef CPU_REGS_SEQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          init_done;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata1;
    logic [DW-1:0] rsp_rdata2;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_di;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_do;

    always #5 clk = ~clk;

    cpu_regs_seq #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .init_done  (init_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata1 (rsp_rdata1),
        .rsp_rdata2 (rsp_rdata2),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_di      (rf_di),
        .rf_raddr   (rf_raddr),
        .rf_do      (rf_do)
    );

    // External regfile_dp stand-in: clocked write, asynchronous read.
    logic [DW-1:0] mem [32];
    always @(posedge clk) if (rf_we) mem[rf_waddr] <= rf_di;
    assign rf_do = mem[rf_raddr];

    logic [DW-1:0] ref_regs [32];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] data;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    vec_t vt [8];

    task automatic chk_w(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit wv,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (a == '0) return '0;
        if (BYP && wv && (wa == a)) return wd;
        return ref_regs[a];
    endfunction

    task automatic init_check;
        for (int i = 0; i < 32; i++) begin
            chk_b("init_we", rf_we, 1'b1);
            chk_w("init_waddr", DW'(rf_waddr), DW'(i));
            chk_w("init_di", rf_di, '0);
            chk_b("init_wr_ready", wr_ready, 1'b0);
            chk_b("init_done_low", init_done, 1'b0);
            tick();
        end
        chk_b("init_done_high", init_done, 1'b1);
        chk_b("post_init_wr_ready", wr_ready, 1'b1);
        chk_b("post_init_req_ready", req_ready, 1'b1);
        chk_b("post_init_we", rf_we, 1'b0);
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    endtask

    task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        #1;
        if (wv) begin
            chk_b("wr_we", rf_we, (wa != '0));
            if (wa != '0) begin
                chk_w("wr_waddr", DW'(rf_waddr), DW'(wa));
                chk_w("wr_di", rf_di, wd);
            end
        end
        @(posedge clk);
        #1;
        if (wv && (wa != '0)) ref_regs[wa] = wd;
        wr_valid = 1'b0;
    endtask

    task automatic read_txn(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input bit wv1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                            input bit wv2, input logic [AW-1:0] wa2, input logic [DW-1:0] wd2,
                            input int hold, input bit use_exp,
                            input logic [DW-1:0] x1, input logic [DW-1:0] x2);
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        rsp_ready = (hold == 0);
        chk_b("idle_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_rs1   = a1;
        req_rs2   = a2;
        tick();
        req_valid = 1'b0;
        chk_w("rd1_raddr", DW'(rf_raddr), DW'(a1));
        chk_b("rd1_req_ready", req_ready, 1'b0);
        chk_b("rd1_rsp_valid", rsp_valid, 1'b0);
        e1 = exp_rd(a1, wv1, wa1, wd1);
        step(wv1, wa1, wd1);
        chk_w("rd2_raddr", DW'(rf_raddr), DW'(a2));
        chk_b("rd2_rsp_valid", rsp_valid, 1'b0);
        e2 = exp_rd(a2, wv2, wa2, wd2);
        step(wv2, wa2, wd2);
        if (use_exp) begin
            e1 = x1;
            e2 = x2;
        end
        chk_b("resp_valid", rsp_valid, 1'b1);
        chk_w("resp_rdata1", rsp_rdata1, e1);
        chk_w("resp_rdata2", rsp_rdata2, e2);
        chk_w("resp_raddr", DW'(rf_raddr), '0);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk_b("hold_valid", rsp_valid, 1'b1);
            chk_w("hold_rdata1", rsp_rdata1, e1);
            chk_w("hold_rdata2", rsp_rdata2, e2);
            chk_b("hold_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        chk_b("after_resp_valid", rsp_valid, 1'b0);
        chk_b("after_resp_req_ready", req_ready, 1'b1);
        chk_w("idle_raddr", DW'(rf_raddr), '0);
    endtask

    initial begin
        logic [AW-1:0] ra1, ra2, wa1, wa2;
        logic [DW-1:0] nine;

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_rs1   = '0;
        req_rs2   = '0;
        rsp_ready = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;

        vt[0] = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
        vt[1] = '{1'b1, 5'd7,  5'd0,  32'h12345678, 32'h0,        32'h0};
        vt[2] = '{1'b0, 5'd5,  5'd7,  32'h0,        32'hDEADBEEF, 32'h12345678};
        vt[3] = '{1'b1, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        32'h0};
        vt[4] = '{1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        vt[5] = '{1'b0, 5'd9,  5'd31, 32'h0,        32'h0,        32'h0};
        vt[6] = '{1'b1, 5'd31, 5'd0,  32'hA5A5A5A5, 32'h0,        32'h0};
        vt[7] = '{1'b0, 5'd31, 5'd5,  32'h0,        32'hA5A5A5A5, 32'hDEADBEEF};

        repeat (3) @(posedge clk);
        #1;
        chk_b("rst_init_done", init_done, 1'b0);
        chk_b("rst_rsp_valid", rsp_valid, 1'b0);
        chk_b("rst_req_ready", req_ready, 1'b0);
        chk_b("rst_wr_ready", wr_ready, 1'b0);
        chk_w("rst_raddr", DW'(rf_raddr), '0);
        chk_w("rst_rdata1", rsp_rdata1, '0);
        chk_w("rst_rdata2", rsp_rdata2, '0);

        // Partial zero-fill, then reset mid-INIT must restart from address 0.
        resetn = 1'b1;
        repeat (10) tick();
        chk_w("mid_init_waddr", DW'(rf_waddr), 32'd10);
        resetn = 1'b0;
        #1;
        chk_w("mid_init_rst_waddr", DW'(rf_waddr), '0);
        tick();
        resetn = 1'b1;
        init_check();

        for (int i = 0; i < 8; i++) begin
            if (vt[i].is_wr) step(1'b1, vt[i].a1, vt[i].data);
            else read_txn(vt[i].a1, vt[i].a2, 1'b0, '0, '0, 1'b0, '0, '0, 0, 1'b1, vt[i].e1, vt[i].e2);
        end

        // Write during RD1 to the register being read.
        step(1'b1, 5'd3, 32'h11);
        read_txn(5'd3, 5'd3, 1'b1, 5'd3, 32'h22, 1'b0, '0, '0, 0, 1'b1,
                 BYP ? 32'h22 : 32'h11, 32'h22);
        read_txn(5'd3, 5'd0, 1'b0, '0, '0, 1'b0, '0, '0, 0, 1'b1, 32'h22, 32'h0);

        // Backpressure for five cycles.
        read_txn(5'd5, 5'd7, 1'b0, '0, '0, 1'b0, '0, '0, 5, 1'b1, 32'hDEADBEEF, 32'h12345678);

        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2))
                step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            wa1 = ($urandom_range(0, 1) == 1) ? ra1 : 5'($urandom_range(0, 7));
            wa2 = ($urandom_range(0, 1) == 1) ? ra2 : 5'($urandom_range(0, 7));
            read_txn(ra1, ra2, 1'($urandom_range(0, 1)), wa1, $urandom,
                     1'($urandom_range(0, 1)), wa2, $urandom,
                     int'($urandom_range(0, 2)), 1'b0, '0, '0);
        end

        // Reset while a response is pending.
        step(1'b1, 5'd5, 32'hCAFEF00D);
        nine = 32'h99;
        step(1'b1, 5'd9, nine);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_rs1   = 5'd5;
        req_rs2   = 5'd9;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk_b("pre_rst_resp_valid", rsp_valid, 1'b1);
        chk_w("pre_rst_rdata2", rsp_rdata2, nine);
        resetn = 1'b0;
        #1;
        chk_b("rst_resp_valid_drop", rsp_valid, 1'b0);
        chk_w("rst_resp_rdata1", rsp_rdata1, '0);
        chk_w("rst_resp_rdata2", rsp_rdata2, '0);
        chk_b("rst_resp_init_done", init_done, 1'b0);
        chk_b("rst_resp_wr_ready", wr_ready, 1'b0);
        tick();
        resetn    = 1'b1;
        rsp_ready = 1'b1;
        init_check();
        read_txn(5'd5, 5'd9, 1'b0, '0, '0, 1'b0, '0, '0, 0, 1'b1, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
